// File: rtl/dac_seq_pkg.sv
// dac_seq_pkg: shared types and default constants for the DAC sample sequencer.
package dac_seq_pkg;
   localparam int DEF_WIDTH    = 10;
   localparam int DEF_CHANNELS = 2;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_DIV_W    = 8;
   localparam int DEF_CW       = (DEF_CHANNELS > 1) ? $clog2(DEF_CHANNELS) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   typedef struct packed {
      logic [DEF_CW-1:0]    chan;
      logic [DEF_WIDTH-1:0] data;
   } sample_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: circular FIFO with wrap-bit pointers; storage itself is never reset.
module sample_fifo #(
   parameter  int DW    = 11,
   parameter  int DEPTH = 8,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);
   logic [DW-1:0] mem [DEPTH];
   logic [LW-1:0] wptr, rptr;
   assign full  = (wptr[LW-1] != rptr[LW-1]) && (wptr[LW-2:0] == rptr[LW-2:0]);
   assign empty = wptr == rptr;
   assign level = wptr - rptr;
   assign rdata = mem[rptr[LW-2:0]];
   always_ff @(posedge CLK or negedge reset)
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   always_ff @(posedge CLK)
      if (push && !flush) mem[wptr[LW-2:0]] <= wdata;
endmodule

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer: paces FIFO'd samples out to per-channel DAC registers
// at a programmable tick rate, flagging underruns.
module dac_sample_sequencer
   import dac_seq_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int CHANNELS = DEF_CHANNELS,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int DIV_W    = DEF_DIV_W,
   localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int LW       = $clog2(DEPTH) + 1
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [CW-1:0]             in_chan,
   input  logic                      enable,
   input  logic                      flush,
   input  logic [DIV_W-1:0]          rate_div,
   input  logic                      clr_underrun,
   output logic [CHANNELS*WIDTH-1:0] dac_d,
   output logic [CHANNELS-1:0]       dac_update,
   output logic [LW-1:0]             level,
   output logic                      underrun
);
   typedef struct packed {
      logic [CW-1:0]    chan;
      logic [WIDTH-1:0] data;
   } entry_t;
   state_t              state, state_nx;
   logic [DIV_W-1:0]    cnt;
   logic                live, full, empty, tick, push, pop;
   entry_t              head;
   logic [CHANNELS-1:0] hit;
   // live keeps in_ready low until the first edge after reset release
   assign in_ready = live && !full && !flush;
   assign push     = in_valid && in_ready;
   assign tick     = (state == RUN) && (cnt == rate_div);
   assign pop      = tick && !empty && !flush;
   sample_fifo #(.DW(CW + WIDTH), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata ({in_chan, in_data}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );
   always_comb state_nx = enable ? RUN : IDLE;
   always_ff @(posedge CLK or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         live     <= 1'b0;
         cnt      <= '0;
         underrun <= 1'b0;
      end else begin
         state    <= state_nx;
         live     <= 1'b1;
         cnt      <= (state == RUN && !tick) ? cnt + 1'b1 : '0;
         underrun <= (tick && empty) || (underrun && !clr_underrun);
      end
   // out-of-range channels match no bit, so they are popped and dropped
   always_comb begin
      hit = '0;
      for (int k = 0; k < CHANNELS; k++) hit[k] = pop && (head.chan == CW'(k));
   end
   always_ff @(posedge CLK or negedge reset)
      if (!reset) begin
         dac_d      <= '0;
         dac_update <= '0;
      end else begin
         dac_update <= hit;
         for (int k = 0; k < CHANNELS; k++)
            if (hit[k]) dac_d[k*WIDTH +: WIDTH] <= head.data;
      end
endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb_dac_sample_sequencer: directed and random stimulus against a queue-based
// reference model of the sequencer.
module tb_dac_sample_sequencer;
   localparam int W = 10, CH = 2, D = 8;
   logic          CLK = 0, reset = 0, in_valid = 0, enable = 0, flush = 0, clr_underrun = 0;
   logic [W-1:0]  in_data = '0;
   logic [0:0]    in_chan = '0;
   logic [7:0]    rate_div = '0;
   logic          in_ready, underrun;
   logic [CH*W-1:0] dac_d;
   logic [CH-1:0] dac_update;
   logic [3:0]    level;
   dac_sample_sequencer dut (
      .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_chan(in_chan), .enable(enable), .flush(flush),
      .rate_div(rate_div), .clr_underrun(clr_underrun), .dac_d(dac_d),
      .dac_update(dac_update), .level(level), .underrun(underrun)
   );
   always #5 CLK = ~CLK;
   int n_tests = 0, n_fail = 0, cyc = 0;
   int q_chan[$], q_data[$];
   bit m_run, m_live, m_unr, rec;
   int m_cnt;
   int m_dac[CH];
   bit [CH-1:0] m_upd;
   int log_cyc[$], log_upd[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_dac();
      return (32'(m_dac[1]) << W) | 32'(m_dac[0]);
   endfunction

   task automatic model_reset();
      q_chan.delete();
      q_data.delete();
      m_run = 0; m_live = 0; m_unr = 0; m_cnt = 0; m_upd = '0;
      for (int k = 0; k < CH; k++) m_dac[k] = 0;
   endtask

   task automatic check_all(input string t);
      check({t, "_dac"}, dac_d, exp_dac());
      check({t, "_upd"}, dac_update, m_upd);
      check({t, "_level"}, level, q_chan.size());
      check({t, "_underrun"}, underrun, m_unr);
      check({t, "_ready"}, in_ready, m_live && q_chan.size() < D && !flush);
   endtask

   task automatic step();
      bit tk, pp, ps, emp;
      int ch, d;
      emp = q_chan.size() == 0;
      ps  = in_valid && m_live && q_chan.size() < D && !flush;
      tk  = m_run && m_cnt == int'(rate_div);
      pp  = tk && !emp && !flush;
      m_upd = '0;
      if (pp) begin
         ch = q_chan.pop_front();
         d  = q_data.pop_front();
         if (ch < CH) begin
            m_dac[ch] = d;
            m_upd[ch] = 1'b1;
         end
      end
      if (tk && emp) m_unr = 1;
      else if (clr_underrun) m_unr = 0;
      if (flush) begin
         q_chan.delete();
         q_data.delete();
      end
      if (ps) begin
         q_chan.push_back(int'(in_chan));
         q_data.push_back(int'(in_data));
      end
      m_cnt  = (m_run && !tk) ? m_cnt + 1 : 0;
      m_run  = enable;
      m_live = 1;
      @(posedge CLK);
      #1;
      cyc++;
      check_all("cyc");
      if (rec && dac_update != 0) begin
         log_cyc.push_back(cyc);
         log_upd.push_back(int'(dac_update));
      end
   endtask

   task automatic push_one(input int ch, input int d);
      in_valid = 1; in_chan = 1'(ch); in_data = W'(d);
      step();
   endtask

   initial begin
      model_reset();
      #12;
      check_all("rst");
      @(posedge CLK); #1;
      reset = 1;
      check_all("rst_rel");
      step();
      check("idle_ready", in_ready, 1);
      check("idle_dac", dac_d, 0);
      // fill to full while idle
      for (int i = 0; i < D; i++) push_one($urandom_range(1, 0), $urandom);
      check("full_level", level, D);
      check("full_ready", in_ready, 0);
      push_one(0, 'h123);
      check("no_9th", level, D);
      flush = 1; step(); flush = 0;
      check("flush_full", level, 0);
      push_one(1, 'h0AA);
      flush = 1; push_one(0, 'h0BB); flush = 0;
      check("flush_push", level, 0);
      // streaming at rate_div=3
      rate_div = 3;
      push_one(0, 'h155); push_one(1, 'h2AA); push_one(0, 'h3FF);
      in_valid = 0; enable = 1; rec = 1;
      repeat (16) step();
      rec = 0;
      check("strm_count", log_cyc.size(), 3);
      if (log_cyc.size() == 3) begin
         check("strm_upd0", log_upd[0], 1);
         check("strm_upd1", log_upd[1], 2);
         check("strm_upd2", log_upd[2], 1);
         check("strm_gap0", log_cyc[1] - log_cyc[0], 4);
         check("strm_gap1", log_cyc[2] - log_cyc[1], 4);
      end
      check("strm_final", dac_d, {10'h2AA, 10'h3FF});
      // underrun
      enable = 0; step();
      rate_div = 0; enable = 1;
      step(); step();
      check("unr_set", underrun, 1);
      check("unr_dac", dac_d, {10'h2AA, 10'h3FF});
      clr_underrun = 1; step();
      check("unr_set_wins", underrun, 1);
      enable = 0; clr_underrun = 0; step();
      clr_underrun = 1; step(); clr_underrun = 0;
      check("unr_clr", underrun, 0);
      // full FIFO streaming every cycle with in_valid held
      for (int i = 0; i < D; i++) push_one($urandom_range(1, 0), $urandom);
      enable = 1;
      repeat (3) step();
      for (int i = 0; i < 6; i++) begin
         in_data = W'($urandom);
         in_chan = 1'($urandom);
         step();
         check("steady_level", level, D - 1);
      end
      in_valid = 0; enable = 0;
      step();
      // random traffic with a mid-run reset
      for (int i = 0; i < 800; i++) begin
         in_valid     = ($urandom % 3) != 0;
         in_data      = W'($urandom);
         in_chan      = 1'($urandom);
         enable       = ($urandom % 8) != 0;
         flush        = ($urandom % 40) == 0;
         clr_underrun = ($urandom % 10) == 0;
         if ($urandom % 50 == 0) rate_div = 8'($urandom % 4);
         if (i == 400) begin
            reset = 0;
            #1;
            model_reset();
            check("mr_dac", dac_d, 0);
            check("mr_level", level, 0);
            check("mr_upd", dac_update, 0);
            check("mr_ready", in_ready, 0);
            check("mr_underrun", underrun, 0);
            #3;
            reset = 1;
         end
         step();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
